// File: rtl/sram_data_mem_ctrl_pkg.sv
// Shared constants and state encoding for the external-SRAM data-memory controller.
package sram_data_mem_ctrl_pkg;

  localparam int SRAM_ADDR_LEN = 18;
  localparam int SRAM_DATA_LEN = 16;
  localparam int DATA_MEM_BASE = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/sram_data_mem_ctrl_if.sv
// MEM-stage request/response bundle between the pipeline and the SRAM controller.
interface sram_data_mem_ctrl_if #(
  parameter int WORD_LEN = 32
);

  logic                MEM_R_EN;
  logic                MEM_W_EN;
  logic [WORD_LEN-1:0] ALU_res;
  logic [WORD_LEN-1:0] ST_value;
  logic [WORD_LEN-1:0] dataMem_out;
  logic                freeze;

  modport master (
    output MEM_R_EN, MEM_W_EN, ALU_res, ST_value,
    input  dataMem_out, freeze
  );

  modport slave (
    input  MEM_R_EN, MEM_W_EN, ALU_res, ST_value,
    output dataMem_out, freeze
  );

endinterface

// File: rtl/sram_data_mem_ctrl_phase_timer.sv
// Per-phase wait counter: reloaded on phase entry, flags the last cycle of the phase.
module sram_phase_timer #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic last
);

  localparam int CW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(WAIT_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == '0);

endmodule

// File: rtl/sram_data_mem_ctrl.sv
// 32-bit MEM-stage data memory on a 16-bit async SRAM: two halfword phases per access.
// Optional one-entry read buffer under `SRAM_CTRL_READ_BUFFER_EN.
module sram_data_mem_ctrl #(
  parameter int WORD_LEN      = 32,
  parameter int SRAM_ADDR_LEN = sram_data_mem_ctrl_pkg::SRAM_ADDR_LEN,
  parameter int SRAM_DATA_LEN = sram_data_mem_ctrl_pkg::SRAM_DATA_LEN,
  parameter int BASE_ADDR     = sram_data_mem_ctrl_pkg::DATA_MEM_BASE,
  parameter int WAIT_CYCLES   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  sram_data_mem_ctrl_if.slave      mem,
  output logic [SRAM_ADDR_LEN-1:0] sram_addr,
  output logic [SRAM_DATA_LEN-1:0] sram_dq_out,
  input  logic [SRAM_DATA_LEN-1:0] sram_dq_in,
  output logic                     sram_dq_oe,
  output logic                     sram_we_n,
  output logic                     sram_oe_n,
  output logic                     sram_ce_n,
  output logic                     sram_ub_n,
  output logic                     sram_lb_n
);

  import sram_data_mem_ctrl_pkg::*;

  localparam int WORD_IDX_LEN = SRAM_ADDR_LEN - 1;

  state_e                    state_q, state_d;
  logic                      op_wr_q, op_wr_d;
  logic [WORD_IDX_LEN-1:0]   word_q, word_d;
  logic [WORD_LEN-1:0]       st_q, st_d;
  logic [SRAM_DATA_LEN-1:0]  rd_lo_q, rd_lo_d;
  logic [WORD_LEN-1:0]       dout_q, dout_d;

  logic                      req;
  logic                      active;
  logic                      hi_phase;
  logic                      phase_last;
  logic                      timer_load;
  logic                      rd_complete;
  logic [WORD_IDX_LEN-1:0]   req_word;
  logic [WORD_LEN-1:0]       rd_word;
  logic                      buf_hit;
  logic [WORD_LEN-1:0]       buf_data;

  assign req         = mem.MEM_R_EN | mem.MEM_W_EN;
  assign req_word    = WORD_IDX_LEN'((mem.ALU_res - WORD_LEN'(BASE_ADDR)) >> 2);
  assign active      = (state_q == ST_LO) | (state_q == ST_HI);
  assign hi_phase    = (state_q == ST_HI);
  assign rd_word     = {sram_dq_in, rd_lo_q};
  assign rd_complete = hi_phase & phase_last & ~op_wr_q;

  sram_phase_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
    .clk   (clk),
    .rst_n (rst),
    .load  (timer_load),
    .last  (phase_last)
  );

`ifdef SRAM_CTRL_READ_BUFFER_EN
  logic                    buf_valid_q, buf_valid_d;
  logic [WORD_IDX_LEN-1:0] buf_word_q, buf_word_d;
  logic [WORD_LEN-1:0]     buf_data_q, buf_data_d;

  assign buf_hit  = mem.MEM_R_EN & ~mem.MEM_W_EN & buf_valid_q & (buf_word_q == req_word)
                    & (state_q == ST_IDLE);
  assign buf_data = buf_data_q;

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_word_d  = buf_word_q;
    buf_data_d  = buf_data_q;
    if ((state_q == ST_IDLE) && mem.MEM_W_EN) begin
      buf_valid_d = 1'b0;
    end else if (rd_complete) begin
      buf_valid_d = 1'b1;
      buf_word_d  = word_q;
      buf_data_d  = rd_word;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid_q <= 1'b0;
      buf_word_q  <= '0;
      buf_data_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_word_q  <= buf_word_d;
      buf_data_q  <= buf_data_d;
    end
  end
`else
  assign buf_hit  = 1'b0;
  assign buf_data = '0;
`endif

  always_comb begin
    state_d    = state_q;
    op_wr_d    = op_wr_q;
    word_d     = word_q;
    st_d       = st_q;
    rd_lo_d    = rd_lo_q;
    dout_d     = dout_q;
    timer_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          op_wr_d = mem.MEM_W_EN;
          word_d  = req_word;
          st_d    = mem.ST_value;
          if (buf_hit) begin
            state_d = ST_DONE;
            dout_d  = buf_data;
          end else begin
            state_d    = ST_LO;
            timer_load = 1'b1;
          end
        end
      end
      ST_LO: begin
        if (phase_last) begin
          if (!op_wr_q) rd_lo_d = sram_dq_in;
          state_d    = ST_HI;
          timer_load = 1'b1;
        end
      end
      ST_HI: begin
        if (phase_last) begin
          if (!op_wr_q) dout_d = rd_word;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      op_wr_q <= 1'b0;
      word_q  <= '0;
      st_q    <= '0;
      rd_lo_q <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      op_wr_q <= op_wr_d;
      word_q  <= word_d;
      st_q    <= st_d;
      rd_lo_q <= rd_lo_d;
      dout_q  <= dout_d;
    end
  end

  // Strobes decode straight from the registered state, so an async reset idles the pads at once.
  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;
    sram_ce_n   = 1'b1;
    sram_ub_n   = 1'b1;
    sram_lb_n   = 1'b1;
    if (active) begin
      sram_addr = {word_q, hi_phase};
      sram_ce_n = 1'b0;
      sram_ub_n = 1'b0;
      sram_lb_n = 1'b0;
      if (op_wr_q) begin
        sram_dq_oe  = 1'b1;
        sram_dq_out = hi_phase ? st_q[WORD_LEN-1:SRAM_DATA_LEN] : st_q[SRAM_DATA_LEN-1:0];
        sram_we_n   = phase_last;
      end else begin
        sram_oe_n = 1'b0;
      end
    end
  end

  assign mem.freeze      = rst & (((state_q == ST_IDLE) & req) | active);
  assign mem.dataMem_out = dout_q;

endmodule

// File: tb/tb_sram_data_mem_ctrl.sv
// Randomized bench for sram_data_mem_ctrl against a transaction-level memory model.
module tb_sram_data_mem_ctrl;

  localparam int W     = 1;
  localparam int PH    = W + 1;
  localparam int STALL = 2 * PH + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe, sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_data_mem_ctrl_if #(.WORD_LEN(32)) bus ();

  sram_data_mem_ctrl #(.WAIT_CYCLES(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem         (bus),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_in  (sram_dq_in),
    .sram_dq_oe  (sram_dq_oe),
    .sram_we_n   (sram_we_n),
    .sram_oe_n   (sram_oe_n),
    .sram_ce_n   (sram_ce_n),
    .sram_ub_n   (sram_ub_n),
    .sram_lb_n   (sram_lb_n)
  );

  // Board SRAM
  logic [15:0] sram [0:262143];
  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? sram[sram_addr] : 16'h0;
  always @(posedge clk)
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) sram[sram_addr] <= sram_dq_out;

  // Word-level reference memory
  logic [31:0] ref_mem [int unsigned];

  function automatic logic [31:0] ref_rd(input int unsigned w);
    if (ref_mem.exists(w)) return ref_mem[w];
    return 32'h0;
  endfunction

  function automatic int unsigned word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return int'((off >> 2) & 32'h1FFFF);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: ph is the cycle index within the current access, -1 when idle
  int          ph = -1;
  bit          op_w, op_hit;
  int unsigned op_word;
  logic [31:0] op_data;
  logic [31:0] exp_dout = 32'h0;
  bit          bv = 1'b0;
  int unsigned bword;
  logic [31:0] bdata;

  always @(negedge clk) begin
    bit exp_freeze, act_ph;
    if (!rst) begin
      ph = -1;
      exp_dout = 32'h0;
      bv = 1'b0;
      chk("rst_dout",   bus.dataMem_out, 32'h0);
      chk("rst_addr",   32'(sram_addr), 32'h0);
      chk("rst_dqout",  32'(sram_dq_out), 32'h0);
      chk("rst_strobe", {27'h0, sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n}, 32'h1F);
      chk("rst_dqoe",   32'(sram_dq_oe), 32'h0);
      chk("rst_freeze", 32'(bus.freeze), 32'h0);
    end else begin
      if (ph >= 0) ph++;
      if (ph < 0 && (bus.MEM_R_EN || bus.MEM_W_EN)) begin
        op_w    = bus.MEM_W_EN;
        op_word = word_of(bus.ALU_res);
        op_data = bus.ST_value;
        op_hit  = 1'b0;
        ph      = 0;
`ifdef SRAM_CTRL_READ_BUFFER_EN
        if (op_w) bv = 1'b0;
        else if (bv && bword == op_word) begin
          op_hit = 1'b1;
          ph     = STALL - 1;
        end
`endif
      end
      exp_freeze = (ph >= 0 && ph < STALL);
      if (ph == STALL) begin
        if (op_w) begin
          ref_mem[op_word] = op_data;
          chk("sram_lo", 32'(sram[op_word * 2]),     32'(op_data[15:0]));
          chk("sram_hi", 32'(sram[op_word * 2 + 1]), 32'(op_data[31:16]));
        end else begin
          exp_dout = op_hit ? bdata : ref_rd(op_word);
          bv = 1'b1; bword = op_word; bdata = exp_dout;
        end
      end
      chk("freeze", 32'(bus.freeze), 32'(exp_freeze));
      chk("dout",   bus.dataMem_out, exp_dout);
      act_ph = !op_hit && ph >= 1 && ph <= 2 * PH;
      if (act_ph) begin
        chk("ce_ub_lb", {29'h0, sram_ce_n, sram_ub_n, sram_lb_n}, 32'h0);
        chk("oe_n",  32'(sram_oe_n),  32'(op_w));
        chk("dq_oe", 32'(sram_dq_oe), 32'(op_w));
        chk("addr",  32'(sram_addr),  op_word * 2 + ((ph > PH) ? 1 : 0));
        chk("we_n",  32'(sram_we_n),  (op_w && ph != PH && ph != 2 * PH) ? 32'h0 : 32'h1);
        if (op_w) chk("dq_out", 32'(sram_dq_out), (ph > PH) ? 32'(op_data[31:16]) : 32'(op_data[15:0]));
      end else begin
        chk("idle_strobe", {27'h0, sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n}, 32'h1F);
        chk("idle_dqoe",   32'(sram_dq_oe), 32'h0);
      end
      if (ph == STALL) ph = -1;
    end
  end

  task automatic set_in(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    bus.MEM_R_EN = r;
    bus.MEM_W_EN = w;
    bus.ALU_res  = a;
    bus.ST_value = d;
  endtask

  // Issue one request and hold the pipeline until freeze drops; inputs are scrambled while frozen.
  task automatic op(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                    output int stall);
    bit done;
    @(posedge clk); #2;
    set_in(r, w, a, d);
    stall = 0;
    done  = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk); #1;
      if (!bus.freeze) begin
        done = 1'b1;
        break;
      end
      stall++;
      @(posedge clk); #2;
      set_in(1'($urandom), 1'($urandom), $urandom, $urandom);
    end
    set_in(1'b0, 1'b0, 32'h0, 32'h0);
    if (!done) chk("op_timeout", 32'(stall), 32'(STALL));
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return 32'd1024 - $urandom_range(1, 16);
    return 32'd1024 + $urandom_range(0, 63);
  endfunction

  initial begin
    int  s;
    bit  found;
    logic [31:0] a;
    rst = 1'b0;
    set_in(1'b0, 1'b0, 32'h0, 32'h0);
    for (int unsigned i = 0; i < 262144; i++) sram[i] = 16'h0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;

    op(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, s);
    chk("w_stall", 32'(s), 32'd5);
    chk("w_addr0", 32'(sram[0]), 32'hBEEF);
    chk("w_addr1", 32'(sram[1]), 32'hDEAD);

    op(1'b1, 1'b0, 32'd1024, 32'h0, s);
    chk("r_stall", 32'(s), 32'd5);
    chk("r_data", bus.dataMem_out, 32'hDEADBEEF);

    op(1'b0, 1'b1, 32'd1033, 32'h12345678, s);
    chk("map_addr4", 32'(sram[4]), 32'h5678);
    chk("map_addr5", 32'(sram[5]), 32'h1234);

    op(1'b1, 1'b0, 32'd1024, 32'h0, s);
    chk("b2b_stall0", 32'(s), 32'd5);
    chk("b2b_data0", bus.dataMem_out, 32'hDEADBEEF);
    op(1'b1, 1'b0, 32'd1028, 32'h0, s);
    chk("b2b_stall1", 32'(s), 32'd5);
    chk("b2b_data1", bus.dataMem_out, 32'h0);

    op(1'b1, 1'b0, 32'd1033, 32'h0, s);
    chk("r_map", bus.dataMem_out, 32'h12345678);
    op(1'b1, 1'b1, 32'd1040, 32'hCAFEF00D, s);
    chk("both_dout", bus.dataMem_out, 32'h12345678);
    chk("both_addr8", 32'(sram[8]), 32'hF00D);
    chk("both_addr9", 32'(sram[9]), 32'hCAFE);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #2;
        set_in(1'b0, 1'b0, $urandom, $urandom);
        @(negedge clk);
      end else begin
        a = rand_addr();
        case ($urandom_range(0, 2))
          0:       op(1'b1, 1'b0, a, $urandom, s);
          1:       op(1'b0, 1'b1, a, $urandom, s);
          default: op(1'b1, 1'b1, a, $urandom, s);
        endcase
      end
    end

    // Abort a write in its first HI cycle: low half landed, high half never did
    @(posedge clk); #2;
    set_in(1'b0, 1'b1, 32'd1100, 32'hA5A51234);
    found = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk); #1;
      if (ph == 3) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) chk("reach_hi", 32'(ph), 32'd3);
    rst = 1'b0;
    if (op_w) begin
      logic [31:0] t;
      t = ref_rd(op_word);
      if (ph >= 2) t[15:0]  = op_data[15:0];
      if (ph >= 4) t[31:16] = op_data[31:16];
      ref_mem[op_word] = t;
    end
    ph = -1;
    #1;
    chk("abort_strobe", {27'h0, sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n}, 32'h1F);
    chk("abort_dqoe",   32'(sram_dq_oe), 32'h0);
    chk("abort_freeze", 32'(bus.freeze), 32'h0);
    chk("abort_addr",   32'(sram_addr), 32'h0);
    @(negedge clk);
    @(negedge clk); #1;
    set_in(1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    op(1'b1, 1'b0, 32'd1100, 32'h0, s);
    chk("post_rst_stall", 32'(s), 32'd5);
    chk("post_rst_data", bus.dataMem_out, 32'h00001234);
    chk("post_rst_hi", 32'(sram[39]), 32'h0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_data_mem_ctrl.md
Name: sram_data_mem_ctrl

Overview:
- Multi-cycle data-memory controller directly downstream of the MEM stage.
- Replaces the single-cycle on-chip data memory with the board's external 16-bit asynchronous SRAM (256K x 16).
- Takes the MEM stage's 32-bit word requests, performs two halfword SRAM accesses per request, and asserts a freeze to hold the pipeline until the access completes.

Parameters:
- WORD_LEN, 32, processor data/address width
- SRAM_ADDR_LEN, 18, SRAM address width
- SRAM_DATA_LEN, 16, SRAM data width
- BASE_ADDR, 1024, byte address mapped to SRAM word 0
- WAIT_CYCLES, 1, extra cycles per halfword phase; minimum 1

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- MEM_R_EN  in  1  load request from MEM stage
- MEM_W_EN  in  1  store request from MEM stage
- ALU_res  in  WORD_LEN  byte address
- ST_value  in  WORD_LEN  store data
- dataMem_out  out  WORD_LEN  load result, valid in DONE
- freeze  out  1  pipeline stall request, active-high
- sram_addr  out  SRAM_ADDR_LEN  SRAM address
- sram_dq_out  out  SRAM_DATA_LEN  write data toward pad
- sram_dq_in  in  SRAM_DATA_LEN  read data from pad
- sram_dq_oe  out  1  pad output enable, 1 = drive
- sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n  out  1 each  SRAM strobes, active-low

Behaviour:
- Reset (rst=0, asynchronous) forces the following, regardless of state:
  - state IDLE
  - dataMem_out=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0
  - all SRAM _n strobes = 1
  - phase counter=0, captured-op registers cleared
- A request is MEM_R_EN | MEM_W_EN. If both are set, the write wins and the read is not performed.
- Address arithmetic:
  - off = ALU_res - BASE_ADDR, 32-bit modulo.
  - word = off[18:2]; ALU_res[1:0] are ignored.
  - Low half at {word,1'b0} holds data[15:0]; high half at {word,1'b1} holds data[31:16].
- States: IDLE, LO, HI, DONE.
  - IDLE: with a request, capture the op type, address and ST_value, go to LO, freeze=1. With no request, freeze=0.
  - LO: drive the low-half address. Stay WAIT_CYCLES+1 cycles, then go to HI.
  - HI: drive the high-half address. Stay WAIT_CYCLES+1 cycles, then go to DONE.
  - DONE: freeze=0 for exactly 1 cycle, then always go to IDLE.
- freeze is combinational: 1 in IDLE when a request is present, 1 in LO and HI, 0 in DONE and in idle IDLE.
- Stall per access = 2*(WAIT_CYCLES+1)+1 cycles. With the default this is 5, i.e. 6 cycles of MEM occupancy.
- Strobes during LO/HI:
  - ce_n=0, ub_n=0, lb_n=0.
  - Read: oe_n=0, dq_oe=0; sram_dq_in is sampled on the last cycle of each phase into the matching half of the read register.
  - Write: oe_n=1, dq_oe=1, sram_dq_out = the matching half. we_n=0 on every phase cycle except the last, giving one cycle of data/address hold.
- dataMem_out is updated only on read completion and otherwise holds its value. A write leaves it unchanged.
- Request inputs are ignored outside IDLE. Once started, an operation always runs to DONE using the captured values, even if the inputs change or drop.
- A new request sampled in IDLE directly after DONE starts a fresh access; there is no overlap.
- A reset mid-access aborts immediately. The SRAM may hold a partially written word; no recovery is attempted.

Optional Feature:
- Macro: SRAM_CTRL_READ_BUFFER_EN.
- Enabled: adds a one-entry buffer holding the word index, data and a valid bit.
  - A read in IDLE whose word matches a valid entry goes IDLE->DONE with freeze=1 for 1 cycle and dataMem_out = buffered data.
  - A completed read fills the buffer.
  - Any write invalidates it.
  - Reset clears valid.
- Disabled: every read takes the full SRAM sequence.

Decomposition:
- Shared package / defines holds:
  - state encoding (2 bits: IDLE, LO, HI, DONE)
  - SRAM_ADDR_LEN, SRAM_DATA_LEN
  - DATA_MEM_BASE (1024)
- Natural sub-module: sram_phase_timer, the wait counter that emits a last-cycle pulse, reloaded on each phase entry.

Test Plan:
- Write: ALU_res=1024, ST_value=0xDEADBEEF, MEM_W_EN=1, WAIT_CYCLES=1 -> sram addr 0 written 0xBEEF, addr 1 written 0xDEAD; freeze=1 for 5 cycles, then 0 in DONE.
- Read back: ALU_res=1024, MEM_R_EN=1 with the SRAM model holding the values above -> dataMem_out=0xDEADBEEF in DONE; freeze=1 for 5 cycles.
- Mapping and alignment: write 0x12345678 at 1033 -> word 2, SRAM addr 4=0x5678, addr 5=0x1234.
- Back-to-back: read at 1024 immediately followed by read at 1028 -> two independent 6-cycle sequences, correct data each; the second starts in the IDLE after DONE.
- Both enables set with ALU_res=1040 -> write performed; dataMem_out keeps its previous value.
- Reset: rst=0 asserted in HI of a write -> same cycle all strobes=1, dq_oe=0, freeze=0. After release, state IDLE and the next read completes normally.
